pll_reconfig_seq: RTL and testbench

//  Sequences the GBA core PLL (3 outputs, fractional VCO, 50 MHz refclk) through power-up reset,

---
 rtl/pll_reconfig_seq.sv | 199 +++++++++++++++++++
 tb/tb_pll_reconfig_seq.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reconfig_seq.sv
// PLL sequencer: power-up reset, lock qualification and run-time reprogramming
// of the core PLL through the Altera reconfig core's Avalon-MM port.
module pll_reconfig_seq #(
  parameter int RST_CYCLES          = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 1048576
) (
  input  logic        refclk,
  input  logic        rst,
  input  logic        cfg_req,
  input  logic [17:0] cfg_n,
  input  logic [17:0] cfg_m,
  input  logic [31:0] cfg_k,
  input  logic [17:0] cfg_c0,
  input  logic [17:0] cfg_c1,
  input  logic [17:0] cfg_c2,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_err,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic [31:0] mgmt_writedata,
  input  logic        mgmt_waitrequest,
  input  logic        pll_locked,
  output logic        pll_rst,
  output logic        clk_ready,
  output logic [2:0]  dbg_state_o
);

  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam logic [RW-1:0] RST_LAST    = RW'(RST_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_MAX  = SW'(LOCK_STABLE_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(LOCK_TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_INIT     = 3'd0,
    S_LOCKWAIT = 3'd1,
    S_IDLE     = 3'd2,
    S_WRITE    = 3'd3,
    S_ERR      = 3'd4
  } state_t;

  state_t        state_q;
  logic          lock_meta_q, lock_sync_q;
  logic [RW-1:0] rst_cnt_q;
  logic [SW-1:0] stable_q, stable_d;
  logic [TW-1:0] timeout_q, timeout_d;
  logic [2:0]    widx_q;
  logic          from_write_q;
  logic [17:0]   n_q, m_q, c0_q, c1_q, c2_q;
  logic [31:0]   k_q;
  logic [5:0]    wr_addr_d;
  logic [31:0]   wr_data_d;
  logic          busy_q, done_q, err_q, mwrite_q, pll_rst_q, ready_q;
  logic [5:0]    addr_q;
  logic [31:0]   data_q;

  // Lock counters saturate; the write word is chosen from the latched config.
  always_comb begin
    stable_d = '0;
    if (lock_sync_q)
      stable_d = (stable_q == STABLE_MAX) ? stable_q : stable_q + SW'(1);
    timeout_d = (timeout_q == TIMEOUT_MAX) ? timeout_q : timeout_q + TW'(1);
    wr_addr_d = 6'd2;
    wr_data_d = 32'd1;
    case (widx_q)
      3'd0: begin wr_addr_d = 6'd0; wr_data_d = 32'd0;               end
      3'd1: begin wr_addr_d = 6'd3; wr_data_d = {14'd0, n_q};        end
      3'd2: begin wr_addr_d = 6'd4; wr_data_d = {14'd0, m_q};        end
      3'd3: begin wr_addr_d = 6'd7; wr_data_d = k_q;                 end
      3'd4: begin wr_addr_d = 6'd5; wr_data_d = {9'd0, 5'd0, c0_q};  end
      3'd5: begin wr_addr_d = 6'd5; wr_data_d = {9'd0, 5'd1, c1_q};  end
      3'd6: begin wr_addr_d = 6'd5; wr_data_d = {9'd0, 5'd2, c2_q};  end
      default: begin wr_addr_d = 6'd2; wr_data_d = 32'd1;            end
    endcase
  end

  // Avalon handshake: a write transfers on an edge where mgmt_write=1 and
  // mgmt_waitrequest=0; until then write/address/data are held unchanged.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q      <= S_INIT;
      lock_meta_q  <= 1'b0;
      lock_sync_q  <= 1'b0;
      rst_cnt_q    <= '0;
      stable_q     <= '0;
      timeout_q    <= '0;
      widx_q       <= '0;
      from_write_q <= 1'b0;
      n_q          <= '0;
      m_q          <= '0;
      k_q          <= '0;
      c0_q         <= '0;
      c1_q         <= '0;
      c2_q         <= '0;
      busy_q       <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      mwrite_q     <= 1'b0;
      pll_rst_q    <= 1'b1;
      ready_q      <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
    end else begin
      lock_meta_q <= pll_locked;
      lock_sync_q <= lock_meta_q;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      case (state_q)
        S_INIT: begin
          if (rst_cnt_q == RST_LAST) begin
            pll_rst_q <= 1'b0;
            stable_q  <= '0;
            timeout_q <= '0;
            state_q   <= S_LOCKWAIT;
          end else begin
            rst_cnt_q <= rst_cnt_q + RW'(1);
          end
        end
        S_LOCKWAIT: begin
          stable_q  <= stable_d;
          timeout_q <= timeout_d;
          if (stable_d == STABLE_MAX) begin
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= from_write_q;
            from_write_q <= 1'b0;
            state_q      <= S_IDLE;
          end else if (timeout_d == TIMEOUT_MAX) begin
            err_q        <= 1'b1;
            from_write_q <= 1'b0;
            state_q      <= S_ERR;
          end
        end
        S_IDLE: begin
          if (!lock_sync_q) begin
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
            stable_q  <= '0;
            timeout_q <= '0;
            state_q   <= S_LOCKWAIT;
          end else if (cfg_req) begin
            n_q      <= cfg_n;
            m_q      <= cfg_m;
            k_q      <= cfg_k;
            c0_q     <= cfg_c0;
            c1_q     <= cfg_c1;
            c2_q     <= cfg_c2;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
            widx_q   <= '0;
            mwrite_q <= 1'b1;
            addr_q   <= 6'd0;
            data_q   <= 32'd0;
            state_q  <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (mwrite_q) begin
            if (!mgmt_waitrequest) begin
              mwrite_q <= 1'b0;
              if (widx_q == 3'd7) begin
                from_write_q <= 1'b1;
                stable_q     <= '0;
                timeout_q    <= '0;
                state_q      <= S_LOCKWAIT;
              end else begin
                widx_q <= widx_q + 3'd1;
              end
            end
          end else begin
            mwrite_q <= 1'b1;
            addr_q   <= wr_addr_d;
            data_q   <= wr_data_d;
          end
        end
        S_ERR: begin
          pll_rst_q <= 1'b1;
          rst_cnt_q <= '0;
          state_q   <= S_INIT;
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  assign cfg_busy       = busy_q;
  assign cfg_done       = done_q;
  assign cfg_err        = err_q;
  assign mgmt_write     = mwrite_q;
  assign mgmt_address   = addr_q;
  assign mgmt_writedata = data_q;
  assign pll_rst        = pll_rst_q;
  assign clk_ready      = ready_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Bench for pll_reconfig_seq: the expected Avalon write list is built from the
// register map and matched against the bus one accepted transfer at a time.
`timescale 1ns/1ps
module tb_pll_reconfig_seq;

  localparam int RST_CYC     = 16;
  localparam int STABLE_CYC  = 8;
  localparam int TIMEOUT_CYC = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_req;
  logic [17:0] cfg_n, cfg_m, cfg_c0, cfg_c1, cfg_c2;
  logic [31:0] cfg_k;
  logic        cfg_busy, cfg_done, cfg_err;
  logic [5:0]  mgmt_address;
  logic        mgmt_write;
  logic [31:0] mgmt_writedata;
  logic        mgmt_waitrequest;
  logic        pll_locked;
  logic        pll_rst, clk_ready;
  logic [2:0]  dbg_state;

  pll_reconfig_seq #(
    .RST_CYCLES(RST_CYC),
    .LOCK_STABLE_CYCLES(STABLE_CYC),
    .LOCK_TIMEOUT_CYCLES(TIMEOUT_CYC)
  ) dut (
    .refclk(clk), .rst(rst), .cfg_req(cfg_req),
    .cfg_n(cfg_n), .cfg_m(cfg_m), .cfg_k(cfg_k),
    .cfg_c0(cfg_c0), .cfg_c1(cfg_c1), .cfg_c2(cfg_c2),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .mgmt_address(mgmt_address), .mgmt_write(mgmt_write),
    .mgmt_writedata(mgmt_writedata), .mgmt_waitrequest(mgmt_waitrequest),
    .pll_locked(pll_locked), .pll_rst(pll_rst), .clk_ready(clk_ready),
    .dbg_state_o(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Scoreboard state
  logic [37:0] exp_q[$];
  int checks = 0, errors = 0;
  int done_cnt = 0, err_cnt = 0, acc_cnt = 0, stall_cnt = 0;
  bit          prev_stall = 1'b0;
  logic [5:0]  prev_addr;
  logic [31:0] prev_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inspect the bus for the coming edge, then advance one clock (sample at +1ns).
  task automatic cycle();
    logic [37:0] w;
    if (!rst) begin
      if (prev_stall) begin
        chk("stall_write_held", mgmt_write, 1);
        chk("stall_addr_held", mgmt_address, prev_addr);
        chk("stall_data_held", mgmt_writedata, prev_data);
      end
      prev_stall = 1'b0;
      if (mgmt_write && !mgmt_waitrequest) begin
        chk("unexpected_write", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          w = exp_q.pop_front();
          chk("wr_addr", mgmt_address, w[37:32]);
          chk("wr_data", mgmt_writedata, w[31:0]);
        end
        acc_cnt++;
      end else if (mgmt_write && mgmt_waitrequest) begin
        prev_stall = 1'b1;
        prev_addr  = mgmt_address;
        prev_data  = mgmt_writedata;
        stall_cnt++;
      end
      if (cfg_done) done_cnt++;
      if (cfg_err)  err_cnt++;
    end else begin
      prev_stall = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // Driver: present a configuration, queue its register-map writes, pulse cfg_req.
  task automatic start_cfg(input logic [17:0] n, input logic [17:0] m, input logic [31:0] k,
                           input logic [17:0] c0, input logic [17:0] c1, input logic [17:0] c2);
    cfg_n = n; cfg_m = m; cfg_k = k; cfg_c0 = c0; cfg_c1 = c1; cfg_c2 = c2;
    exp_q.push_back({6'd0, 32'd0});
    exp_q.push_back({6'd3, 14'd0, n});
    exp_q.push_back({6'd4, 14'd0, m});
    exp_q.push_back({6'd7, k});
    exp_q.push_back({6'd5, 9'd0, 5'd0, c0});
    exp_q.push_back({6'd5, 9'd0, 5'd1, c1});
    exp_q.push_back({6'd5, 9'd0, 5'd2, c2});
    exp_q.push_back({6'd2, 32'd1});
    cfg_req = 1'b1;
    cycle();
    cfg_req = 1'b0;
    chk("req_mgmt_write", mgmt_write, 1);
    chk("req_busy", cfg_busy, 1);
    chk("req_clk_ready_low", clk_ready, 0);
  endtask

  // Driver: answer the write sequence. stop_at>=0 leaves once that many writes
  // were accepted and the next is on the bus; noise_req pokes cfg_req/cfg_* mid-sequence.
  task automatic run_writes(input int stall_idx, input int stall_len, input bit rand_wait,
                            input int stop_at, input bit noise_req);
    int base, left, guard;
    base = acc_cnt; left = stall_len; guard = 0;
    while (exp_q.size() > 0 && guard < 1000) begin
      if (stop_at >= 0 && acc_cnt - base == stop_at && mgmt_write) break;
      if (mgmt_write && acc_cnt - base == stall_idx && left > 0) begin
        mgmt_waitrequest = 1'b1;
        left--;
      end else begin
        mgmt_waitrequest = rand_wait ? ($urandom_range(0, 2) == 0) : 1'b0;
      end
      if (noise_req && acc_cnt - base == 1) begin
        cfg_req = 1'b1;
        cfg_n = 18'($urandom); cfg_m = 18'($urandom); cfg_k = $urandom;
        cfg_c0 = 18'($urandom); cfg_c1 = 18'($urandom); cfg_c2 = 18'($urandom);
      end else begin
        cfg_req = 1'b0;
      end
      cycle();
      guard++;
    end
    mgmt_waitrequest = 1'b0;
    cfg_req = 1'b0;
    chk("write_seq_bounded", guard < 1000, 1);
  endtask

  task automatic wait_ready(input string tag);
    int guard;
    guard = 0;
    while (!(cfg_busy === 1'b0 && clk_ready === 1'b1) && guard < 2000) begin
      cycle();
      guard++;
    end
    chk(tag, guard < 2000, 1);
  endtask

  task automatic count_pll_rst(input string tag);
    int cnt;
    cnt = 0;
    while (pll_rst === 1'b1 && cnt < 100) begin
      cnt++;
      cycle();
    end
    chk(tag, cnt, RST_CYC);
  endtask

  initial begin
    int total, cnt, low, rst_hi, d0, e0, a0, s0;
    rst = 1'b1; pll_locked = 1'b1; cfg_req = 1'b0; mgmt_waitrequest = 1'b0;
    cfg_n = '0; cfg_m = '0; cfg_k = '0; cfg_c0 = '0; cfg_c1 = '0; cfg_c2 = '0;
    repeat (3) @(posedge clk);
    #1;

    // Reset values
    chk("rst_pll_rst", pll_rst, 1);
    chk("rst_busy", cfg_busy, 1);
    chk("rst_clk_ready", clk_ready, 0);
    chk("rst_mgmt_write", mgmt_write, 0);
    chk("rst_addr", mgmt_address, 0);
    chk("rst_data", mgmt_writedata, 0);
    chk("rst_done", cfg_done, 0);
    chk("rst_err", cfg_err, 0);

    // Power-up: pll_rst pulse length and lock qualification time
    rst = 1'b0;
    cnt = 0;
    while (pll_rst === 1'b1 && cnt < 100) begin
      cnt++;
      cycle();
    end
    chk("init_pll_rst_len", cnt, RST_CYC);
    total = cnt;
    while (clk_ready !== 1'b1 && total < 200) begin
      cycle();
      total++;
    end
    chk("init_ready_in_time", total <= RST_CYC + STABLE_CYC + 3, 1);
    chk("init_busy_low", cfg_busy, 0);
    chk("init_no_done", done_cnt, 0);

    // Directed reprogram, no stalls
    d0 = done_cnt; a0 = acc_cnt;
    start_cfg(18'h00404, 18'h01010, 32'h80000000,
              18'($urandom), 18'($urandom), 18'($urandom));
    run_writes(-1, 0, 1'b0, -1, 1'b0);
    chk("dir_queue_empty", exp_q.size(), 0);
    wait_ready("dir_ready");
    repeat (5) cycle();
    chk("dir_done_once", done_cnt - d0, 1);
    chk("dir_write_count", acc_cnt - a0, 8);

    // Same request, K write stalled 5 cycles, cfg_req/cfg_* noise while busy
    d0 = done_cnt; a0 = acc_cnt; s0 = stall_cnt;
    start_cfg(18'h00404, 18'h01010, 32'h80000000,
              18'($urandom), 18'($urandom), 18'($urandom));
    run_writes(3, 5, 1'b0, -1, 1'b1);
    wait_ready("stall_ready");
    repeat (10) cycle();
    chk("stall_cycles", stall_cnt - s0, 5);
    chk("stall_done_once", done_cnt - d0, 1);
    chk("stall_write_count", acc_cnt - a0, 8);

    // Random configurations with random waitrequest
    for (int t = 0; t < 4; t++) begin
      d0 = done_cnt; a0 = acc_cnt;
      start_cfg(18'($urandom), 18'($urandom), $urandom,
                18'($urandom), 18'($urandom), 18'($urandom));
      run_writes(-1, 0, 1'b1, -1, 1'b0);
      wait_ready("rand_ready");
      repeat (3) cycle();
      chk("rand_done_once", done_cnt - d0, 1);
      chk("rand_write_count", acc_cnt - a0, 8);
    end

    // Lock never returns after START: timeout, error pulse, PLL reset re-pulse
    d0 = done_cnt; e0 = err_cnt;
    start_cfg(18'($urandom), 18'($urandom), $urandom,
              18'($urandom), 18'($urandom), 18'($urandom));
    pll_locked = 1'b0;
    run_writes(-1, 0, 1'b0, -1, 1'b0);
    cnt = 0;
    while (cfg_err !== 1'b1 && cnt < 500) begin
      cycle();
      cnt++;
    end
    chk("timeout_cycles", cnt, TIMEOUT_CYC);
    chk("timeout_pll_rst_low_at_err", pll_rst, 0);
    cycle();
    count_pll_rst("timeout_pll_rst_len");
    pll_locked = 1'b1;
    wait_ready("timeout_recover");
    chk("timeout_err_once", err_cnt - e0, 1);
    chk("timeout_no_done", done_cnt - d0, 0);

    // One-cycle lock glitch in IDLE: requalify without PLL reset or cfg_done
    d0 = done_cnt; low = 0; rst_hi = 0;
    pll_locked = 1'b0;
    cycle();
    pll_locked = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (pll_rst) rst_hi++;
      if (!clk_ready) low++;
      cycle();
    end
    chk("glitch_low_min", low >= STABLE_CYC, 1);
    chk("glitch_low_max", low <= STABLE_CYC + 3, 1);
    chk("glitch_no_pll_rst", rst_hi, 0);
    chk("glitch_ready_back", clk_ready, 1);
    chk("glitch_no_done", done_cnt - d0, 0);

    // Asynchronous reset while write 4 is on the bus
    d0 = done_cnt; a0 = acc_cnt;
    start_cfg(18'($urandom), 18'($urandom), $urandom,
              18'($urandom), 18'($urandom), 18'($urandom));
    run_writes(-1, 0, 1'b0, 4, 1'b0);
    chk("abort_write4_presented", mgmt_write, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_mgmt_write_low", mgmt_write, 0);
    chk("abort_pll_rst_high", pll_rst, 1);
    chk("abort_busy", cfg_busy, 1);
    chk("abort_clk_ready_low", clk_ready, 0);
    exp_q.delete();
    prev_stall = 1'b0;
    repeat (2) cycle();
    rst = 1'b0;
    count_pll_rst("abort_pll_rst_len");
    wait_ready("abort_recover");
    chk("abort_write_count", acc_cnt - a0, 4);
    chk("abort_no_done", done_cnt - d0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired before the sequence completed");
    $fatal(1, "watchdog");
  end

endmodule
